rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbitration of NREQ write requesters onto a
// single register-file write port. After reset, and on request, it runs an
// automatic clear that writes zero to addresses 1..2^AWL-1.
module rf_write_arbiter #(
  parameter int unsigned AWL  = 8,
  parameter int unsigned DWL  = 32,
  parameter int unsigned NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_req,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*AWL-1:0]       req_addr,
  input  logic [NREQ*DWL-1:0]       req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      wen,
  output logic [AWL-1:0]            WA,
  output logic [DWL-1:0]            WD,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  state_t           r_state;
  logic [AWL-1:0]   r_cnt;
  logic [IDW-1:0]   r_last;
  logic             r_wen;
  logic [AWL-1:0]   r_wa;
  logic [DWL-1:0]   r_wd;
  logic [IDW-1:0]   r_gid;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [AWL-1:0]   w_cnt_nxt;
  logic [IDW-1:0]   w_last_nxt;
  logic             w_wen_nxt;
  logic [AWL-1:0]   w_wa_nxt;
  logic [DWL-1:0]   w_wd_nxt;
  logic [IDW-1:0]   w_gid_nxt;
  logic             w_busy_nxt;
  logic [NREQ-1:0]  w_ready;
  logic             w_found;
  logic [IDW-1:0]   w_sel;
  int unsigned      w_idx;
  logic [AWL-1:0]   w_sel_addr;
  logic [DWL-1:0]   w_sel_data;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_last) + k + 1) % NREQ;
      if (!w_found && req_valid[IDW'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = IDW'(w_idx);
      end
    end
  end

  // Extract the selected requester's address and data payload.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_sel) begin
        w_sel_addr = req_addr[i*AWL +: AWL];
        w_sel_data = req_data[i*DWL +: DWL];
      end
    end
  end

  // Next-state and next-output logic for the clear/arbitrate FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_wen_nxt   = 1'b0;
    w_wa_nxt    = r_wa;
    w_wd_nxt    = r_wd;
    w_gid_nxt   = r_gid;
    w_busy_nxt  = 1'b0;
    w_ready     = '0;
    case (r_state)
      CLEAR: begin
        // Clear requests are ignored here; the sequence never restarts.
        w_wen_nxt  = 1'b1;
        w_wa_nxt   = r_cnt;
        w_wd_nxt   = '0;
        w_busy_nxt = 1'b1;
        if (r_cnt == {AWL{1'b1}}) begin
          w_state_nxt = ARB;
        end else begin
          w_cnt_nxt = r_cnt + AWL'(1);
        end
      end
      ARB: begin
        if (clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = AWL'(1);
        end else if (w_found) begin
          w_ready[w_sel] = 1'b1;
          w_last_nxt     = w_sel;
          w_gid_nxt      = w_sel;
          // Address 0 is hard-wired zero: accept the request but suppress the write.
          if (w_sel_addr != '0) begin
            w_wen_nxt = 1'b1;
            w_wa_nxt  = w_sel_addr;
            w_wd_nxt  = w_sel_data;
          end
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = AWL'(1);
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= AWL'(1);
      r_last  <= IDW'(NREQ - 1);
      r_wen   <= 1'b0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_gid   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_wen   <= w_wen_nxt;
      r_wa    <= w_wa_nxt;
      r_wd    <= w_wd_nxt;
      r_gid   <= w_gid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Ready is combinational and forced low while reset is held.
  assign req_ready = rst ? '0 : w_ready;
  assign wen       = r_wen;
  assign WA        = r_wa;
  assign WD        = r_wd;
  assign grant_id  = r_gid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_rf_write_arbiter;

  localparam int unsigned AWL  = 3;
  localparam int unsigned DWL  = 8;
  localparam int unsigned NREQ = 4;

  logic                 clk;
  logic                 rst;
  logic                 clr_req;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AWL-1:0]  req_addr;
  logic [NREQ*DWL-1:0]  req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wen;
  logic [AWL-1:0]       WA;
  logic [DWL-1:0]       WD;
  logic [1:0]           grant_id;
  logic                 busy;

  rf_write_arbiter #(.AWL(AWL), .DWL(DWL), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wen(wen), .WA(WA), .WD(WD),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wen;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [1:0] gid;
    logic       busy;
  } rec_t;

  rec_t q[$];
  int   checks;
  int   failures;

  // Pending requests per requester (held until accepted).
  bit       pv[NREQ];
  bit [2:0] pa[NREQ];
  bit [7:0] pd[NREQ];

  // Reference model: clear progress, round-robin pointer, visible port values.
  bit       m_clear;
  int       m_next;
  int       m_last;
  bit [2:0] m_wa;
  bit [7:0] m_wd;
  int       m_gid;

  task automatic step(input bit r, input bit c);
    rec_t            e;
    int              acc;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    rst     = r;
    clr_req = c;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]            = pv[i];
      req_addr[i*AWL +: AWL]  = pa[i];
      req_data[i*DWL +: DWL]  = pd[i];
    end
    #1;
    acc     = -1;
    exp_rdy = '0;
    e.wen   = 1'b0;
    e.busy  = 1'b0;
    if (r) begin
      m_clear = 1'b1; m_next = 1; m_last = NREQ - 1;
      m_wa = '0; m_wd = '0; m_gid = 0;
    end else if (m_clear) begin
      e.wen = 1'b1; e.busy = 1'b1;
      m_wa = 3'(m_next); m_wd = '0;
      if (m_next == 7) m_clear = 1'b0;
      else m_next++;
    end else if (c) begin
      m_clear = 1'b1; m_next = 1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_last + 1 + k) % NREQ;
        if (acc < 0 && pv[i]) acc = i;
      end
      if (acc >= 0) begin
        exp_rdy[acc] = 1'b1;
        m_last = acc;
        m_gid  = acc;
        if (pa[acc] != 0) begin
          e.wen = 1'b1; m_wa = pa[acc]; m_wd = pd[acc];
        end
      end
    end
    e.wa  = m_wa;
    e.wd  = m_wd;
    e.gid = 2'(m_gid);
    checks++;
    if (req_ready !== exp_rdy) begin
      failures++;
      $display("FAIL ready t=%0t: got %b expected %b", $time, req_ready, exp_rdy);
    end
    q.push_back(e);
    if (acc >= 0) pv[acc] = 1'b0;
  endtask

  // Monitor: compare registered port values against the scoreboard each cycle.
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (wen !== e.wen || WA !== e.wa || WD !== e.wd ||
            grant_id !== e.gid || busy !== e.busy) begin
          failures++;
          $display("FAIL port t=%0t: got wen=%b WA=%0d WD=%h gid=%0d busy=%b expected wen=%b WA=%0d WD=%h gid=%0d busy=%b",
                   $time, wen, WA, WD, grant_id, busy, e.wen, e.wa, e.wd, e.gid, e.busy);
        end
      end
    end
  end

  task automatic clear_pending();
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
  endtask

  initial begin
    int guard;
    checks = 0; failures = 0;
    rst = 1'b1; clr_req = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    m_clear = 1'b1; m_next = 1; m_last = NREQ - 1; m_wa = '0; m_wd = '0; m_gid = 0;
    clear_pending();

    // Reset for two cycles, then idle through the automatic clear.
    step(1, 0); step(1, 0);
    repeat (9) step(0, 0);

    // All requesters continuously valid: rotation 0,1,2,3,0.
    repeat (5) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i]) begin
          pv[i] = 1'b1; pa[i] = 3'(i + 1); pd[i] = 8'hA0 + 8'(i);
        end
      end
      step(0, 0);
    end
    clear_pending();
    step(0, 0);

    // Requester 2 writes address 0: accepted, no write enable.
    pv[2] = 1'b1; pa[2] = 3'd0; pd[2] = 8'hFF;
    step(0, 0); step(0, 0);

    // Clear pulse with requesters 1 and 3 pending.
    pv[1] = 1'b1; pa[1] = 3'd5; pd[1] = 8'h11;
    pv[3] = 1'b1; pa[3] = 3'd6; pd[3] = 8'h33;
    step(0, 1);
    repeat (10) step(0, 0);

    // Second clear pulse while the counter is at 4 is ignored.
    step(0, 1);
    for (int k = 0; k < 9; k++) step(0, k == 3);

    // Reset at clear counter 5 aborts; clear restarts from 1.
    step(0, 1);
    repeat (4) step(0, 0);
    step(1, 0);
    repeat (10) step(0, 0);

    // Random traffic with occasional clear and reset.
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i] = 1'b1; pa[i] = 3'($urandom_range(7, 0)); pd[i] = 8'($urandom);
        end
      end
      step($urandom_range(149, 0) == 0, $urandom_range(39, 0) == 0);
    end
    clear_pending();
    step(0, 0);

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected outputs never observed", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
